// File: rtl/slice_sequential_adder.sv
// Multi-cycle wide adder/subtractor: one 5-bit carry-look-ahead slice per clock,
// LSB slice first, with a registered carry linking consecutive slices.
module slice_sequential_adder #(
  parameter int NSLICES = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 sub,
  input  logic [5*NSLICES-1:0] A,
  input  logic [5*NSLICES-1:0] B,
  input  logic                 cin,
  output logic [5*NSLICES-1:0] R,
  output logic                 cout,
  output logic                 overflow,
  output logic                 busy,
  output logic                 done
);

  localparam int W  = 5 * NSLICES;
  localparam int KW = (NSLICES > 1) ? $clog2(NSLICES) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NSLICES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // 5-bit carry-look-ahead slice: returns {carry_out, sum}
  function automatic logic [5:0] cla5(input logic [4:0] a, input logic [4:0] b, input logic c);
    logic [4:0] g, p;
    logic [5:0] cc;
    g = a & b;
    p = a ^ b;
    cc[0] = c;
    cc[1] = g[0] | (p[0] & c);
    cc[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c);
    cc[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c);
    cc[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
          | (p[3] & p[2] & p[1] & p[0] & c);
    cc[5] = g[4] | (p[4] & g[3]) | (p[4] & p[3] & g[2]) | (p[4] & p[3] & p[2] & g[1])
          | (p[4] & p[3] & p[2] & p[1] & g[0]) | (p[4] & p[3] & p[2] & p[1] & p[0] & c);
    return {cc[5], p ^ cc[4:0]};
  endfunction

  state_t        state_q, state_d;
  logic [W-1:0]  opa_q, opa_d, opb_q, opb_d, r_q, r_d;
  logic [KW-1:0] k_q, k_d;
  logic          carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
  logic          busy_q, busy_d, done_q, done_d;
  logic [5:0]    slice;
  int            base;

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    r_d     = r_q;
    k_d     = k_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    busy_d  = busy_q;
    done_d  = done_q;
    base    = 5 * int'(k_q);
    slice   = cla5(opa_q[base +: 5], opb_q[base +: 5], carry_q);

    unique case (state_q)
      IDLE, DONE: begin
        done_d = 1'b0;
        if (start) begin
          opa_d   = A;
          opb_d   = sub ? ~B : B;
          carry_d = cin;
          r_d     = '0;
          k_d     = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        r_d[base +: 5] = slice[4:0];
        carry_d        = slice[5];
        if (k_q == K_LAST) begin
          // Carry into the MSB xor carry out of it flags signed overflow
          cout_d  = slice[5];
          ovf_d   = opa_q[W-1] ^ opb_q[W-1] ^ slice[4] ^ slice[5];
          k_d     = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      r_q     <= '0;
      k_q     <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      k_q     <= k_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
    // Operand latches carry no reset; they are always reloaded on accept
    opa_q <= opa_d;
    opb_q <= opb_d;
  end

  assign R        = r_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_slice_sequential_adder.sv
// Randomized self-checking bench for slice_sequential_adder against an
// arithmetic reference model of full-width add/subtract.
module tb_slice_sequential_adder;

  localparam int NSLICES = 4;
  localparam int W       = 5 * NSLICES;
  localparam logic [W-1:0] MASK = {W{1'b1}};

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         cin = 1'b0;
  logic [W-1:0] R;
  logic         cout, overflow, busy, done;

  int n_tests = 0;
  int n_fail  = 0;

  slice_sequential_adder #(.NSLICES(NSLICES)) dut (
    .clk(clk), .reset(reset), .start(start), .sub(sub), .A(A), .B(B), .cin(cin),
    .R(R), .cout(cout), .overflow(overflow), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_tests++;
    if (obs !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, want);
    end
  endtask

  // Advance one rising edge, then settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain W+1-bit arithmetic, signed overflow from operand/result signs.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                       input logic s, output logic [W-1:0] r, output logic co, output logic ov);
    logic [W-1:0] bb;
    logic [W:0]   full;
    bb   = s ? (~b & MASK) : b;
    full = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, c};
    r    = full[W-1:0];
    co   = full[W];
    ov   = (a[W-1] == bb[W-1]) && (r[W-1] != a[W-1]);
  endtask

  // Drive an op, take the accept edge, drop start; check busy rises, R clears,
  // and cout/overflow hold their previous values.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input logic s);
    logic pc, po;
    pc = cout; po = overflow;
    A = a; B = b; cin = c; sub = s; start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("accept_busy", busy, 1);
    check_eq("accept_R_clear", R, 0);
    check_eq("accept_cout_hold", cout, pc);
    check_eq("accept_ovf_hold", overflow, po);
  endtask

  // Wait (bounded) for done; check the latency and the delivered result.
  task automatic wait_done(input string tag, input int exp_cyc, input logic [W-1:0] er,
                           input logic eco, input logic eov);
    int n;
    n = 0;
    while (!done && n < 20) begin
      if (busy !== 1'b1) break;
      tick();
      n++;
    end
    check_eq({tag, "_latency"}, n, exp_cyc);
    check_eq({tag, "_done"}, done, 1);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_R"}, R, er);
    check_eq({tag, "_cout"}, cout, eco);
    check_eq({tag, "_ovf"}, overflow, eov);
  endtask

  task automatic idle_after(input string tag, input logic [W-1:0] er);
    tick();
    check_eq({tag, "_done_fall"}, done, 0);
    check_eq({tag, "_idle_busy"}, busy, 0);
    check_eq({tag, "_R_hold"}, R, er);
  endtask

  initial begin
    logic [W-1:0] a, b, er;
    logic         c, s, eco, eov;
    int           dcnt;

    // Reset with start held high: nothing may be accepted
    reset = 1'b1; start = 1'b1; A = 20'h12345; B = 20'h1;
    tick(); tick();
    check_eq("rst_R", R, 0);
    check_eq("rst_cout", cout, 0);
    check_eq("rst_ovf", overflow, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    reset = 1'b0; start = 1'b0;
    tick();
    check_eq("post_rst_busy", busy, 0);

    // Directed cases
    start_op(20'hFFFFF, 20'h00001, 1'b0, 1'b0);
    wait_done("add_wrap", NSLICES, 20'h00000, 1'b1, 1'b0);
    idle_after("add_wrap", 20'h00000);

    start_op(20'h00005, 20'h00007, 1'b1, 1'b1);
    wait_done("sub_borrow", NSLICES, 20'hFFFFE, 1'b0, 1'b0);
    idle_after("sub_borrow", 20'hFFFFE);

    start_op(20'h00007, 20'h00005, 1'b1, 1'b1);
    wait_done("sub_pos", NSLICES, 20'h00002, 1'b1, 1'b0);
    idle_after("sub_pos", 20'h00002);

    start_op(20'h7FFFF, 20'h00001, 1'b0, 1'b0);
    wait_done("ovf_pos", NSLICES, 20'h80000, 1'b0, 1'b1);
    idle_after("ovf_pos", 20'h80000);

    start_op(20'h80000, 20'h80000, 1'b0, 1'b0);
    wait_done("ovf_neg", NSLICES, 20'h00000, 1'b1, 1'b1);
    idle_after("ovf_neg", 20'h00000);

    // Start pulsed mid-RUN with new operands is ignored
    start_op(20'h01234, 20'h00111, 1'b0, 1'b0);
    tick(); tick();
    A = 20'hAAAAA; B = 20'h55555; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("ign_start", NSLICES - 3, 20'h01345, 1'b0, 1'b0);
    idle_after("ign_start", 20'h01345);

    // Back-to-back: start held through the done cycle
    start_op(20'h00010, 20'h00020, 1'b0, 1'b0);
    wait_done("b2b_first", NSLICES, 20'h00030, 1'b0, 1'b0);
    A = 20'h1; B = 20'h2; cin = 1'b0; sub = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("b2b_accept_busy", busy, 1);
    check_eq("b2b_accept_done", done, 0);
    check_eq("b2b_accept_R", R, 0);
    wait_done("b2b_second", NSLICES, 20'h00003, 1'b0, 1'b0);
    idle_after("b2b_second", 20'h00003);

    // Abort with reset on the third RUN cycle
    start_op(20'h12345, 20'h11111, 1'b0, 1'b0);
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("abort_R", R, 0);
    check_eq("abort_cout", cout, 0);
    check_eq("abort_ovf", overflow, 0);
    check_eq("abort_busy", busy, 0);
    check_eq("abort_done", done, 0);
    dcnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done || busy) dcnt++;
    end
    check_eq("abort_no_done", dcnt, 0);
    start_op(20'h12345, 20'h11111, 1'b0, 1'b0);
    wait_done("after_abort", NSLICES, 20'h23456, 1'b0, 1'b0);
    idle_after("after_abort", 20'h23456);

    // Randomized ops; inputs are scrambled after accept to prove latching
    for (int i = 0; i < 40; i++) begin
      a = W'($urandom) & MASK;
      b = W'($urandom) & MASK;
      c = 1'($urandom_range(0, 1));
      s = 1'($urandom_range(0, 1));
      if (i % 8 == 0) b = a;
      model(a, b, c, s, er, eco, eov);
      start_op(a, b, c, s);
      A = W'($urandom); B = W'($urandom); cin = ~c; sub = ~s;
      wait_done("rand", NSLICES, er, eco, eov);
      idle_after("rand", er);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
